// File: rtl/qblock_item_dispenser.sv
// Question-block item dispenser: per-car roulette spin, item hold and
// one-cycle use event, both channels fed from one free-running Galois LFSR.
module qblock_item_dispenser #(
  parameter int          ITEM_WIDTH  = 2,
  parameter int          NUM_ITEMS   = 3,
  parameter int          SPIN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  i_render_clk,
  input  logic                  i_rst_n,
  input  logic                  i_car1_collision,
  input  logic                  i_car2_collision,
  input  logic                  i_car1_use,
  input  logic                  i_car2_use,
  output logic [ITEM_WIDTH-1:0] o_car1_item,
  output logic [ITEM_WIDTH-1:0] o_car2_item,
  output logic                  o_car1_spinning,
  output logic                  o_car2_spinning,
  output logic                  o_car1_use_valid,
  output logic                  o_car2_use_valid,
  output logic [ITEM_WIDTH-1:0] o_car1_use_item,
  output logic [ITEM_WIDTH-1:0] o_car2_use_item
);

  localparam int              CNT_W     = (SPIN_FRAMES > 1) ? $clog2(SPIN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_FRAMES - 1);
  localparam logic [7:0]      NUM_B     = 8'(NUM_ITEMS);
  localparam logic [15:0]     LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_SPIN,
    S_HOLD
  } state_t;

  state_t                state_q     [2];
  state_t                state_d     [2];
  logic [CNT_W-1:0]      spin_cnt_q  [2];
  logic [CNT_W-1:0]      spin_cnt_d  [2];
  logic [ITEM_WIDTH-1:0] held_item_q [2];
  logic [ITEM_WIDTH-1:0] held_item_d [2];
  logic [ITEM_WIDTH-1:0] item_q      [2];
  logic [ITEM_WIDTH-1:0] item_d      [2];
  logic [ITEM_WIDTH-1:0] use_item_q  [2];
  logic [ITEM_WIDTH-1:0] use_item_d  [2];
  logic [ITEM_WIDTH-1:0] roll        [2];

  logic [1:0]  spinning_q;
  logic [1:0]  spinning_d;
  logic [1:0]  use_valid_q;
  logic [1:0]  use_valid_d;
  logic [1:0]  use_prev_q;
  logic [1:0]  use_prev_d;
  logic [1:0]  collision;
  logic [1:0]  use_in;
  logic [1:0]  rise;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign collision = {i_car2_collision, i_car1_collision};
  assign use_in    = {i_car2_use, i_car1_use};
  assign rise      = use_in & ~use_prev_q;

  always_comb begin
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    use_prev_d = use_in;
    roll[0]    = ITEM_WIDTH'((lfsr_q[7:0]  % NUM_B) + 8'd1);
    roll[1]    = ITEM_WIDTH'((lfsr_q[15:8] % NUM_B) + 8'd1);
  end

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      state_d[c]     = state_q[c];
      spin_cnt_d[c]  = spin_cnt_q[c];
      held_item_d[c] = held_item_q[c];
      item_d[c]      = '0;
      use_valid_d[c] = 1'b0;
      use_item_d[c]  = '0;
      case (state_q[c])
        S_EMPTY: begin
          if (collision[c]) begin
            state_d[c]    = S_SPIN;
            spin_cnt_d[c] = '0;
            item_d[c]     = roll[c];
          end
        end
        S_SPIN: begin
          item_d[c] = roll[c];
          if (spin_cnt_q[c] == SPIN_LAST) begin
            state_d[c]     = S_HOLD;
            held_item_d[c] = roll[c];
            spin_cnt_d[c]  = '0;
          end else begin
            spin_cnt_d[c] = spin_cnt_q[c] + CNT_W'(1);
          end
        end
        S_HOLD: begin
          // Use wins over a same-cycle collision; the collision is dropped.
          if (rise[c]) begin
            state_d[c]     = S_EMPTY;
            use_valid_d[c] = 1'b1;
            use_item_d[c]  = held_item_q[c];
            held_item_d[c] = '0;
          end else begin
            item_d[c] = held_item_q[c];
          end
        end
        default: begin
          state_d[c] = S_EMPTY;
        end
      endcase
      spinning_d[c] = (state_d[c] == S_SPIN);
    end
  end

  always_ff @(posedge i_render_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q      <= LFSR_SEED;
      use_prev_q  <= '0;
      spinning_q  <= '0;
      use_valid_q <= '0;
      for (int unsigned c = 0; c < 2; c++) begin
        state_q[c]     <= S_EMPTY;
        spin_cnt_q[c]  <= '0;
        held_item_q[c] <= '0;
        item_q[c]      <= '0;
        use_item_q[c]  <= '0;
      end
    end else begin
      lfsr_q      <= lfsr_d;
      use_prev_q  <= use_prev_d;
      spinning_q  <= spinning_d;
      use_valid_q <= use_valid_d;
      for (int unsigned c = 0; c < 2; c++) begin
        state_q[c]     <= state_d[c];
        spin_cnt_q[c]  <= spin_cnt_d[c];
        held_item_q[c] <= held_item_d[c];
        item_q[c]      <= item_d[c];
        use_item_q[c]  <= use_item_d[c];
      end
    end
  end

  assign o_car1_item      = item_q[0];
  assign o_car2_item      = item_q[1];
  assign o_car1_spinning  = spinning_q[0];
  assign o_car2_spinning  = spinning_q[1];
  assign o_car1_use_valid = use_valid_q[0];
  assign o_car2_use_valid = use_valid_q[1];
  assign o_car1_use_item  = use_item_q[0];
  assign o_car2_use_item  = use_item_q[1];

endmodule

// File: tb/tb_qblock_item_dispenser.sv
// Bench for qblock_item_dispenser: scenario tasks plus randomized traffic,
// checked against a frame-level reference model of the item rules.
module tb_qblock_item_dispenser;

  localparam int ITEM_WIDTH  = 2;
  localparam int NUM_ITEMS   = 3;
  localparam int SPIN_FRAMES = 60;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  car1_col = 1'b0, car2_col = 1'b0;
  logic                  car1_use = 1'b0, car2_use = 1'b0;
  logic [ITEM_WIDTH-1:0] car1_item, car2_item, car1_uitem, car2_uitem;
  logic                  car1_spin, car2_spin, car1_valid, car2_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qblock_item_dispenser #(
    .ITEM_WIDTH (ITEM_WIDTH),
    .NUM_ITEMS  (NUM_ITEMS),
    .SPIN_FRAMES(SPIN_FRAMES),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .i_render_clk    (clk),
    .i_rst_n         (rst_n),
    .i_car1_collision(car1_col),
    .i_car2_collision(car2_col),
    .i_car1_use      (car1_use),
    .i_car2_use      (car2_use),
    .o_car1_item     (car1_item),
    .o_car2_item     (car2_item),
    .o_car1_spinning (car1_spin),
    .o_car2_spinning (car2_spin),
    .o_car1_use_valid(car1_valid),
    .o_car2_use_valid(car2_valid),
    .o_car1_use_item (car1_uitem),
    .o_car2_use_item (car2_uitem)
  );

  // Reference model: a car is either spinning with some frames left, holding
  // an item, or empty.
  int          m_frames [2];
  int          m_held   [2];
  int          m_item   [2];
  int          m_uitem  [2];
  logic        m_valid  [2];
  logic        m_prev   [2];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      for (int c = 0; c < 2; c++) begin
        m_frames[c] <= 0; m_held[c] <= 0; m_item[c] <= 0;
        m_uitem[c]  <= 0; m_valid[c] <= 1'b0; m_prev[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        automatic logic col = (c == 0) ? car1_col : car2_col;
        automatic logic use_b = (c == 0) ? car1_use : car2_use;
        automatic int byte_v = (c == 0) ? int'(m_lfsr[7:0]) : int'(m_lfsr[15:8]);
        automatic int r = (byte_v % NUM_ITEMS) + 1;
        automatic int f = m_frames[c];
        automatic int h = m_held[c];
        automatic int it = 0;
        automatic int ui = 0;
        automatic logic v = 1'b0;
        automatic logic rise = use_b && !m_prev[c];
        if (f > 0) begin
          f = f - 1;
          it = r;
          if (f == 0) h = r;
        end else if (h != 0) begin
          if (rise) begin v = 1'b1; ui = h; h = 0; end
          else it = h;
        end else if (col) begin
          f = SPIN_FRAMES;
          it = r;
        end
        m_frames[c] <= f; m_held[c] <= h; m_item[c] <= it;
        m_uitem[c] <= ui; m_valid[c] <= v; m_prev[c] <= use_b;
      end
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  logic [13:0] dut_vec, mdl_vec;
  assign dut_vec = {car1_spin, car1_item, car1_valid, car1_uitem,
                    car2_spin, car2_item, car2_valid, car2_uitem};
  assign mdl_vec = {m_frames[0] > 0, 2'(m_item[0]), m_valid[0], 2'(m_uitem[0]),
                    m_frames[1] > 0, 2'(m_item[1]), m_valid[1], 2'(m_uitem[1])};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_vec !== 14'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 14'h0 || dut.lfsr_q !== m_lfsr) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: outputs %h lfsr %h want 0 lfsr %h", i, dut_vec, dut.lfsr_q, m_lfsr);
      end
    end
  endtask

  task automatic test_spin_car1();
    int spin_cycles = 0;
    int changes = 0;
    logic [1:0] last_item = '0;
    @(negedge clk); car1_col = 1'b1;
    @(negedge clk); car1_col = 1'b0;
    for (int i = 0; i < SPIN_FRAMES + 3; i++) begin
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL spin_model_c%0d: got %h want %h", i, dut_vec, mdl_vec);
      end
      if (car1_spin) begin
        spin_cycles++;
        if (i > 0 && car1_item != last_item) changes++;
      end
      last_item = car1_item;
      @(negedge clk);
    end
    n_checks++;
    if (spin_cycles != SPIN_FRAMES) begin
      n_fail++; $display("FAIL spin_length: got %0d want %0d", spin_cycles, SPIN_FRAMES);
    end
    n_checks++;
    if (changes == 0) begin
      n_fail++; $display("FAIL spin_rolling: item changes %0d want >0", changes);
    end
    n_checks++;
    if (car1_item < 1 || car1_item > NUM_ITEMS || car2_item !== 2'd0) begin
      n_fail++; $display("FAIL hold_range: car1 %0d car2 %0d want 1..%0d and 0", car1_item, car2_item, NUM_ITEMS);
    end
  endtask

  task automatic test_use();
    int held = m_held[0];
    int pulses = 0;
    repeat (5) @(negedge clk);
    car1_use = 1'b1;
    @(negedge clk);
    n_checks++;
    if (car1_valid !== 1'b1 || int'(car1_uitem) != held || car1_item !== 2'd0) begin
      n_fail++; $display("FAIL use_pulse: valid %b item %0d hud %0d want 1 %0d 0", car1_valid, car1_uitem, car1_item, held);
    end
    @(negedge clk);
    n_checks++;
    if (car1_valid !== 1'b0 || car1_uitem !== 2'd0) begin
      n_fail++; $display("FAIL use_one_cycle: valid %b item %0d want 0 0", car1_valid, car1_uitem);
    end
    car1_use = 1'b0;
    @(negedge clk); car1_use = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (car1_valid) pulses++;
    end
    car1_use = 1'b0;
    n_checks++;
    if (pulses != 0 || dut_vec !== mdl_vec) begin
      n_fail++; $display("FAIL use_second_press: pulses %0d vec %h want 0 %h", pulses, dut_vec, mdl_vec);
    end
  endtask

  task automatic test_use_held();
    int pulses = 0;
    @(negedge clk); car1_use = 1'b1; car1_col = 1'b1;
    @(negedge clk); car1_col = 1'b0;
    for (int i = 0; i < SPIN_FRAMES + 10; i++) begin
      if (car1_valid) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 0 || car1_item == 2'd0 || car1_spin) begin
      n_fail++; $display("FAIL held_button: pulses %0d item %0d spin %b want 0 nonzero 0", pulses, car1_item, car1_spin);
    end
    car1_use = 1'b0;
    @(negedge clk); car1_use = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (car1_valid) pulses++;
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL held_repress_c%0d: got %h want %h", i, dut_vec, mdl_vec);
      end
    end
    car1_use = 1'b0;
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL held_repress_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_collision_spam();
    logic [1:0] held;
    car2_col = 1'b1;
    for (int i = 0; i < SPIN_FRAMES + 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL spam_c%0d: got %h want %h", i, dut_vec, mdl_vec);
      end
    end
    held = car2_item;
    n_checks++;
    if (car2_spin !== 1'b0 || int'(held) != m_held[1] || held == 2'd0) begin
      n_fail++; $display("FAIL spam_hold: spin %b item %0d want 0 %0d", car2_spin, held, m_held[1]);
    end
    car2_use = 1'b1;
    @(negedge clk);
    car2_col = 1'b0; car2_use = 1'b0;
    n_checks++;
    if (car2_valid !== 1'b1 || car2_uitem !== held || car2_spin !== 1'b0 || car2_item !== 2'd0) begin
      n_fail++; $display("FAIL col_use_same: valid %b item %0d spin %b hud %0d want 1 %0d 0 0", car2_valid, car2_uitem, car2_spin, car2_item, held);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (car2_spin !== 1'b0 || dut_vec !== mdl_vec) begin
      n_fail++; $display("FAIL col_use_no_respin: got %h want %h", dut_vec, mdl_vec);
    end
  endtask

  task automatic test_both_and_reset();
    @(negedge clk); car1_col = 1'b1; car2_col = 1'b1;
    @(negedge clk); car1_col = 1'b0; car2_col = 1'b0;
    for (int i = 0; i < 24; i++) begin
      n_checks++;
      if (dut_vec !== mdl_vec || !car1_spin || !car2_spin) begin
        n_fail++; $display("FAIL both_spin_c%0d: got %h want %h", i, dut_vec, mdl_vec);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 14'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", dut_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 14'h0 || dut.lfsr_q !== m_lfsr) begin
        n_fail++; $display("FAIL post_reset_c%0d: got %h lfsr %h want 0 lfsr %h", i, dut_vec, dut.lfsr_q, m_lfsr);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== mdl_vec) begin
        n_fail++; $display("FAIL random_c%0d: got %h want %h", i, dut_vec, mdl_vec);
      end
      car1_col = ($urandom_range(0, 29) == 0);
      car2_col = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) car1_use = ~car1_use;
      if ($urandom_range(0, 7) == 0) car2_use = ~car2_use;
    end
    car1_col = 1'b0; car2_col = 1'b0; car1_use = 1'b0; car2_use = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spin_car1();
    test_use();
    test_use_held();
    test_collision_spam();
    test_both_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
